// File: rtl/pipe_pkg.sv
// Shared types for the pipeline and its pack stage: lane width, lane type and pack FSM states.
package pipe_pkg;

  localparam int unsigned DATA_W = 5;

  typedef logic [DATA_W-1:0] lane_t;

  typedef enum logic {
    StFilling,
    StFullWait
  } pack_state_e;

endpackage

// File: rtl/pipe_pack_stage_if.sv
// Valid/ready bundle for the pack stage: narrow beats in, packed wide words out.
interface pipe_pack_stage_if #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned LANES  = 4
);

  localparam int unsigned CntW = $clog2(LANES + 1);

  logic [DATA_W-1:0]       input_val;
  logic                    pipe_in_valid;
  logic                    pipe_in_rdy;
  logic [LANES*DATA_W-1:0] output_word;
  logic [CntW-1:0]         output_cnt;
  logic                    pipe_out_valid;
  logic                    pipe_out_rdy;

  modport master (
    output input_val, pipe_in_valid, pipe_out_rdy,
    input  pipe_in_rdy, output_word, output_cnt, pipe_out_valid
  );

  modport slave (
    input  input_val, pipe_in_valid, pipe_out_rdy,
    output pipe_in_rdy, output_word, output_cnt, pipe_out_valid
  );

endinterface

// File: rtl/pipe_pack_outreg.sv
// Valid/ready output holding register; a load on the drain edge replaces the word with no bubble.
module pipe_pack_outreg #(
  parameter int unsigned WordW = 20,
  parameter int unsigned CntW  = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WordW-1:0] load_word_i,
  input  logic [CntW-1:0]  load_cnt_i,
  input  logic             out_rdy_i,
  output logic             out_valid_o,
  output logic [WordW-1:0] out_word_o,
  output logic [CntW-1:0]  out_cnt_o
);

  logic             valid_q;
  logic [WordW-1:0] word_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      word_q  <= load_word_i;
      cnt_q   <= load_cnt_i;
    end else if (out_rdy_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_word_o  = word_q;
  assign out_cnt_o   = cnt_q;

endmodule

// File: rtl/pipe_pack_stage.sv
// Packs LANES narrow beats into one wide word. Optional partial-word flush under PIPE_PACK_FLUSH_EN.
module pipe_pack_stage #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned LANES  = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
`ifdef PIPE_PACK_FLUSH_EN
  input  logic               flush_i,
`endif
  pipe_pack_stage_if.slave   bus
);

  import pipe_pkg::*;

  localparam int unsigned CntW  = $clog2(LANES + 1);
  localparam int unsigned WordW = LANES * DATA_W;

  pack_state_e                  state_q;
  logic [CntW-1:0]              cnt_q, cnt_next;
  logic [LANES-1:0][DATA_W-1:0] coll_q, coll_next;

  logic             accept, flush, slot_free, close, load;
  logic [WordW-1:0] load_word;
  logic [CntW-1:0]  load_cnt;

`ifdef PIPE_PACK_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Ready depends on state only, so downstream ready never reaches upstream combinationally.
  assign bus.pipe_in_rdy = !reset_i && (state_q == StFilling);
  assign accept          = bus.pipe_in_valid && bus.pipe_in_rdy;
  assign slot_free       = !bus.pipe_out_valid || bus.pipe_out_rdy;

  always_comb begin
    coll_next = coll_q;
    cnt_next  = cnt_q;
    if (accept) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (cnt_q == CntW'(i)) coll_next[i] = bus.input_val;
      end
      cnt_next = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    close     = (state_q == StFilling) &&
                ((accept && cnt_q == CntW'(LANES - 1)) || (flush && cnt_next != '0));
    load      = close ? slot_free : ((state_q == StFullWait) && bus.pipe_out_rdy);
    load_word = (state_q == StFullWait) ? coll_q : coll_next;
    load_cnt  = (state_q == StFullWait) ? cnt_q : cnt_next;
  end

  // Collector is cleared whenever a word leaves it, which keeps unused lanes zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StFilling;
      cnt_q   <= '0;
      coll_q  <= '0;
    end else begin
      unique case (state_q)
        StFilling: begin
          if (close && slot_free) begin
            cnt_q  <= '0;
            coll_q <= '0;
          end else begin
            cnt_q  <= cnt_next;
            coll_q <= coll_next;
            if (close) state_q <= StFullWait;
          end
        end
        StFullWait: begin
          if (bus.pipe_out_rdy) begin
            state_q <= StFilling;
            cnt_q   <= '0;
            coll_q  <= '0;
          end
        end
      endcase
    end
  end

  pipe_pack_outreg #(
    .WordW(WordW),
    .CntW (CntW)
  ) u_outreg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .load_word_i(load_word),
    .load_cnt_i (load_cnt),
    .out_rdy_i  (bus.pipe_out_rdy),
    .out_valid_o(bus.pipe_out_valid),
    .out_word_o (bus.output_word),
    .out_cnt_o  (bus.output_cnt)
  );

endmodule

// File: tb/tb_pipe_pack_stage.sv
// Bench for pipe_pack_stage: directed steps plus random traffic against a beat-list reference model.
module tb_pipe_pack_stage;

  import pipe_pkg::*;

  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = LANES * DATA_W;
  localparam int unsigned CNT_W  = $clog2(LANES + 1);
`ifdef PIPE_PACK_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i;
  logic flush;

  always #5 clk = ~clk;

  pipe_pack_stage_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  pipe_pack_stage #(
    .DATA_W(DATA_W),
    .LANES (LANES)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
`ifdef PIPE_PACK_FLUSH_EN
    .flush_i(flush),
`endif
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_words = 0;

  lane_t             pending[$];
  logic [WORD_W-1:0] exp_word[$];
  int                exp_cnt[$];

  logic              s_valid, s_in_rdy, s_acc;
  logic [WORD_W-1:0] s_word;
  logic [CNT_W-1:0]  s_cnt;
  logic              held = 1'b0;
  logic [WORD_W-1:0] held_word;
  logic [CNT_W-1:0]  held_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every LANES accepted beats (or a flush with beats pending) make one word.
  task automatic form_word();
    logic [WORD_W-1:0] w;
    w = '0;
    foreach (pending[i]) w = w | (WORD_W'(pending[i]) << (DATA_W * i));
    exp_word.push_back(w);
    exp_cnt.push_back(pending.size());
    pending.delete();
  endtask

  task automatic cycle(input bit v, input lane_t d, input bit ordy, input bit fl);
    bus.pipe_in_valid = v;
    bus.input_val     = d;
    bus.pipe_out_rdy  = ordy;
    flush             = fl;
    @(negedge clk);
    s_valid  = bus.pipe_out_valid;
    s_word   = bus.output_word;
    s_cnt    = bus.output_cnt;
    s_in_rdy = bus.pipe_in_rdy;
    s_acc    = v && bus.pipe_in_rdy && !reset_i;
    if (reset_i) begin
      pending.delete();
      exp_word.delete();
      exp_cnt.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(s_valid), 32'd1);
        chk("hold_word", 32'(s_word), 32'(held_word));
        chk("hold_cnt", 32'(s_cnt), 32'(held_cnt));
      end
      if (s_valid && ordy) begin
        n_words++;
        chk("word_expected", 32'(exp_word.size() > 0), 32'd1);
        if (exp_word.size() > 0) begin
          chk("out_word", 32'(s_word), 32'(exp_word.pop_front()));
          chk("out_cnt", 32'(s_cnt), 32'(exp_cnt.pop_front()));
        end
      end
      if (s_acc) pending.push_back(d);
      if (pending.size() > 0 && (pending.size() == LANES || (FLUSH_ON && fl))) form_word();
      held      = s_valid && !ordy;
      held_word = s_word;
      held_cnt  = s_cnt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    cycle(1'b1, lane_t'(0), 1'b1, 1'b0);
    chk("rst_in_rdy", 32'(s_in_rdy), 32'd0);
    reset_i = 1'b0;
  endtask

  initial begin
    int b;
    int t;
    int w0;
    reset_i           = 1'b1;
    flush             = 1'b0;
    bus.pipe_in_valid = 1'b0;
    bus.input_val     = '0;
    bus.pipe_out_rdy  = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    cycle(1'b0, lane_t'(0), 1'b0, 1'b0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_word", 32'(s_word), 32'd0);
    chk("rst_cnt", 32'(s_cnt), 32'd0);
    chk("post_rst_in_rdy", 32'(s_in_rdy), 32'd1);

    // Four beats, downstream always ready.
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, lane_t'(k), 1'b1, 1'b0);
      chk("t1_in_rdy", 32'(s_in_rdy), 32'd1);
    end
    cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("t1_valid", 32'(s_valid), 32'd1);
    chk("t1_word", 32'(s_word), 32'h20C41);
    chk("t1_cnt", 32'(s_cnt), 32'd4);
    cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("t1_one_cycle", 32'(s_valid), 32'd0);

    // Backpressure: two words buffered, ninth beat stalls.
    for (int k = 1; k <= 8; k++) cycle(1'b1, lane_t'(k), 1'b0, 1'b0);
    chk("t2_beat8_acc", 32'(s_acc), 32'd1);
    cycle(1'b1, lane_t'(9), 1'b0, 1'b0);
    chk("t2_stall_rdy", 32'(s_in_rdy), 32'd0);
    chk("t2_held_word", 32'(s_word), 32'h20C41);
    cycle(1'b1, lane_t'(9), 1'b1, 1'b0);
    chk("t2_drain_rdy", 32'(s_in_rdy), 32'd0);
    chk("t2_first_word", 32'(s_word), 32'h20C41);
    cycle(1'b1, lane_t'(9), 1'b1, 1'b0);
    chk("t2_rdy_after", 32'(s_in_rdy), 32'd1);
    chk("t2_second_valid", 32'(s_valid), 32'd1);
    chk("t2_second_word", 32'(s_word), 32'h41CC5);
    chk("t2_beat9_acc", 32'(s_acc), 32'd1);

    // Reset mid-word drops the partial collector.
    do_reset();
    w0 = n_words;
    cycle(1'b1, lane_t'(1), 1'b1, 1'b0);
    cycle(1'b1, lane_t'(2), 1'b1, 1'b0);
    do_reset();
    for (int k = 5; k <= 8; k++) cycle(1'b1, lane_t'(k), 1'b1, 1'b0);
    cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("t3_word", 32'(s_word), 32'h41CC5);
    for (int k = 0; k < 3; k++) cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("t3_one_word", 32'(n_words - w0), 32'd1);

    // Continuous beats with toggling downstream ready.
    do_reset();
    w0 = n_words;
    b  = 0;
    t  = 0;
    while (b < 12 && t < 200) begin
      cycle(1'b1, lane_t'(b), 1'(t % 2), 1'b0);
      if (s_acc) b++;
      t++;
    end
    chk("t4_all_beats", 32'(b), 32'd12);
    for (int k = 0; k < 6; k++) cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("t4_three_words", 32'(n_words - w0), 32'd3);
    chk("t4_drained", 32'(exp_word.size()), 32'd0);

`ifdef PIPE_PACK_FLUSH_EN
    // Flush of a partial word, then a fresh word starting in lane 0.
    do_reset();
    cycle(1'b1, lane_t'(9), 1'b1, 1'b0);
    cycle(1'b1, lane_t'(10), 1'b1, 1'b0);
    cycle(1'b0, lane_t'(0), 1'b1, 1'b1);
    cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("fl_valid", 32'(s_valid), 32'd1);
    chk("fl_word", 32'(s_word), 32'h149);
    chk("fl_cnt", 32'(s_cnt), 32'd2);
    for (int k = 1; k <= 4; k++) cycle(1'b1, lane_t'(k), 1'b1, 1'b0);
    cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("fl_next_word", 32'(s_word), 32'h20C41);
    do_reset();
    cycle(1'b0, lane_t'(0), 1'b1, 1'b1);
    cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("fl_empty_valid", 32'(s_valid), 32'd0);
    cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("fl_empty_valid2", 32'(s_valid), 32'd0);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 120) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), lane_t'($urandom), 1'($urandom_range(0, 2) != 0),
              FLUSH_ON && ($urandom_range(0, 7) == 0));
      end
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, lane_t'(0), 1'b1, 1'b0);
    chk("rand_drained", 32'(exp_word.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
